// File: rtl/scu_dsp_dma_resp_pkg.sv
// scu_dsp_dma_pkg: shared types and constants for the SCU-side DSP DMA responder.
//   DspDmaState_t : responder FSM states
//   DMAI_*        : bit positions of the fields in the DMA instruction word
//   AddStep()     : write-direction address increment (in words) for an ADD code
package scu_dsp_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    WR_ACK,
    WR_MEM,
    RD_MEM,
    RD_ACK,
    DONE,
    END2
  } DspDmaState_t;

  localparam int unsigned DMAI_DIR_BIT  = 12;
  localparam int unsigned DMAI_HOLD_BIT = 14;
  localparam int unsigned DMAI_ADD_LSB  = 15;

  function automatic logic [6:0] AddStep(input logic [2:0] add);
    logic [6:0] step;
    case (add)
      3'd0:    step = 7'd0;
      3'd1:    step = 7'd1;
      3'd2:    step = 7'd2;
      3'd3:    step = 7'd4;
      3'd4:    step = 7'd8;
      3'd5:    step = 7'd16;
      3'd6:    step = 7'd32;
      default: step = 7'd64;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/scu_dsp_dma_resp.sv
// scu_dsp_dma_resp: SCU-side responder for the DSP D0-bus DMA engine.
// Holds RA0/WA0, latches the DMA instruction on DMAW, and turns each DSP
// beat request into one word transfer on the SCU memory bus.
// Ports:
//   CLK, RST_N (async, active-low), RES_N (sync soft reset, active-low)
//   CE_R / CE_F           : DSP clock-phase enables (only CE_R is used)
//   DSO, RA0W, WA0W, DMAW : DSP register writes and DMA start
//   DMA_REQ/DO/LAST       : DSP beat request, write data, final-beat flag
//   DMA_DI/ACK/END        : read data, beat handshake, completion strobe
//   MEM_A/DO/WE/REQ       : SCU bus request (byte address, held until MEM_ACK)
//   MEM_DI/ACK            : SCU bus read data and completion pulse
//   BUSY                  : transfer in progress
module scu_dsp_dma_resp
  import scu_dsp_dma_pkg::*;
#(
  parameter int AW = 25
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RES_N,
  input  logic          CE_R,
  input  logic          CE_F,
  input  logic [31:0]   DSO,
  input  logic          RA0W,
  input  logic          WA0W,
  input  logic          DMAW,
  input  logic          DMA_REQ,
  input  logic [31:0]   DMA_DO,
  input  logic          DMA_LAST,
  output logic [31:0]   DMA_DI,
  output logic          DMA_ACK,
  output logic          DMA_END,
  output logic [AW+1:0] MEM_A,
  output logic [31:0]   MEM_DO,
  output logic          MEM_WE,
  output logic          MEM_REQ,
  input  logic [31:0]   MEM_DI,
  input  logic          MEM_ACK,
  output logic          BUSY
);

  DspDmaState_t  state;
  logic [AW-1:0] ra0, wa0, cur, cur_next;
  logic          dir, hold, last;
  logic [2:0]    add;

  logic unused_inputs;
  assign unused_inputs = ^{CE_F, DSO[31:AW]};

  always_comb begin
    cur_next = cur + (dir ? AW'(AddStep(add)) : AW'(1));
  end

  assign MEM_A = {cur, 2'b00};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ra0 <= '0; wa0 <= '0; cur <= '0;
      dir <= 1'b0; hold <= 1'b0; add <= '0; last <= 1'b0;
      DMA_DI <= '0; DMA_ACK <= 1'b0; DMA_END <= 1'b0;
      MEM_DO <= '0; MEM_WE <= 1'b0; MEM_REQ <= 1'b0; BUSY <= 1'b0;
    end else if (!RES_N) begin
      state <= IDLE;
      ra0 <= '0; wa0 <= '0; cur <= '0;
      dir <= 1'b0; hold <= 1'b0; add <= '0; last <= 1'b0;
      DMA_DI <= '0; DMA_ACK <= 1'b0; DMA_END <= 1'b0;
      MEM_DO <= '0; MEM_WE <= 1'b0; MEM_REQ <= 1'b0; BUSY <= 1'b0;
    end else begin
      if (!BUSY && RA0W) ra0 <= DSO[AW-1:0];
      if (!BUSY && WA0W) wa0 <= DSO[AW-1:0];

      case (state)
        // DMAW is a one-CLK strobe like RA0W/WA0W, so it is taken on any CLK.
        IDLE: begin
          if (DMAW) begin
            dir   <= DSO[DMAI_DIR_BIT];
            hold  <= DSO[DMAI_HOLD_BIT];
            add   <= DSO[DMAI_ADD_LSB +: 3];
            cur   <= DSO[DMAI_DIR_BIT] ? wa0 : ra0;
            BUSY  <= 1'b1;
            state <= WAIT_REQ;
          end
        end

        WAIT_REQ: begin
          if (CE_R && DMA_REQ) begin
            last <= DMA_LAST;
            if (dir) begin
              MEM_DO  <= DMA_DO;
              DMA_ACK <= 1'b1;
              state   <= WR_ACK;
            end else begin
              MEM_REQ <= 1'b1;
              MEM_WE  <= 1'b0;
              state   <= RD_MEM;
            end
          end
        end

        WR_ACK: begin
          if (CE_R) begin
            DMA_ACK <= 1'b0;
            MEM_REQ <= 1'b1;
            MEM_WE  <= 1'b1;
            state   <= WR_MEM;
          end
        end

        WR_MEM: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            MEM_WE  <= 1'b0;
            cur     <= cur_next;
            state   <= last ? DONE : WAIT_REQ;
          end
        end

        RD_MEM: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            DMA_DI  <= MEM_DI;
            cur     <= cur_next;
            state   <= RD_ACK;
          end
        end

        // DMA_ACK itself marks which of the two CE_R edges this is.
        RD_ACK: begin
          if (CE_R) begin
            if (!DMA_ACK) begin
              DMA_ACK <= 1'b1;
            end else begin
              DMA_ACK <= 1'b0;
              state   <= last ? DONE : WAIT_REQ;
            end
          end
        end

        DONE: begin
          if (CE_R) begin
            if (!hold) begin
              if (dir) wa0 <= cur;
              else     ra0 <= cur;
            end
            DMA_END <= 1'b1;
            state   <= END2;
          end
        end

        END2: begin
          if (CE_R) begin
            DMA_END <= 1'b0;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scu_dsp_dma_resp.sv
// tb_scu_dsp_dma_resp: directed bench for scu_dsp_dma_resp.
// A table of single-beat write transfers covers the ADD step lookup, HOLD and
// wrap; hand-written sequences cover multi-beat writes/reads, soft reset
// mid-transfer and strobes issued while BUSY. RA0/WA0 contents are observed
// by a follow-up single-beat "probe" transfer that uses HOLD=1 and ADD=0.
module tb_scu_dsp_dma_resp;

  localparam int AW = 25;

  logic          CLK = 1'b0;
  logic          RST_N, RES_N, CE_R, CE_F;
  logic [31:0]   DSO;
  logic          RA0W, WA0W, DMAW, DMA_REQ, DMA_LAST;
  logic [31:0]   DMA_DO, DMA_DI, MEM_DO, MEM_DI;
  logic          DMA_ACK, DMA_END, MEM_WE, MEM_REQ, MEM_ACK, BUSY;
  logic [AW+1:0] MEM_A;

  scu_dsp_dma_resp #(.AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .RES_N(RES_N), .CE_R(CE_R), .CE_F(CE_F),
    .DSO(DSO), .RA0W(RA0W), .WA0W(WA0W), .DMAW(DMAW),
    .DMA_REQ(DMA_REQ), .DMA_DO(DMA_DO), .DMA_LAST(DMA_LAST),
    .DMA_DI(DMA_DI), .DMA_ACK(DMA_ACK), .DMA_END(DMA_END),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ),
    .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  int end_cnt = 0;
  logic mem_auto = 1'b1;

  logic [AW+1:0] log_addr[$];
  logic          log_we[$];
  logic [31:0]   log_data[$];
  logic [31:0]   rd_q[$];
  logic [31:0]   wdat[8];
  logic [31:0]   rdat[8];
  logic          rstab[8];

  typedef struct {
    logic [AW-1:0] wa0;
    logic [2:0]    add;
    logic          hold;
    logic [31:0]   data;
    logic [AW+1:0] exp_addr;
    logic [AW+1:0] exp_probe;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [AW+1:0] a,
                         input logic we, input logic [31:0] d);
    if (idx >= log_addr.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no memory cycle #%0d expected one", name, idx);
    end else begin
      chk(name, {log_we[idx], log_addr[idx], log_data[idx]}, {we, a, d});
    end
  endtask

  // CE_R / CE_F alternate, one CLK each out of every four
  initial begin
    int cnt = 0;
    CE_R = 1'b0; CE_F = 1'b0;
    forever begin
      @(negedge CLK);
      CE_R = (cnt == 0);
      CE_F = (cnt == 2);
      cnt = (cnt + 1) % 4;
    end
  end

  // memory: acknowledges a request after two CLKs and logs the cycle
  initial begin
    int lat = 0;
    MEM_ACK = 1'b0; MEM_DI = '0;
    forever begin
      @(negedge CLK);
      if (mem_auto) begin
        if (MEM_ACK) begin
          MEM_ACK = 1'b0;
        end else if (MEM_REQ) begin
          lat++;
          if (lat >= 2) begin
            lat = 0;
            MEM_ACK = 1'b1;
            if (!MEM_WE) MEM_DI = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            log_addr.push_back(MEM_A);
            log_we.push_back(MEM_WE);
            log_data.push_back(MEM_WE ? MEM_DO : MEM_DI);
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  // rising-edge counters for DMA_ACK and DMA_END
  initial begin
    logic ack_q = 1'b0, end_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (DMA_ACK && !ack_q) ack_cnt++;
      if (DMA_END && !end_q) end_cnt++;
      ack_q = DMA_ACK;
      end_q = DMA_END;
    end
  end

  task automatic set_ra0(input logic [31:0] v);
    @(negedge CLK); DSO = v; RA0W = 1'b1;
    @(negedge CLK); RA0W = 1'b0;
  endtask

  task automatic set_wa0(input logic [31:0] v);
    @(negedge CLK); DSO = v; WA0W = 1'b1;
    @(negedge CLK); WA0W = 1'b0;
  endtask

  task automatic dmaw(input logic dir, input logic hold, input logic [2:0] add);
    logic [31:0] ins;
    ins = '0;
    ins[12] = dir;
    ins[14] = hold;
    ins[17:15] = add;
    @(negedge CLK); DSO = ins; DMAW = 1'b1;
    @(negedge CLK); DMAW = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic lst,
                      output logic [31:0] rd, output logic stable);
    bit got = 0;
    rd = '0; stable = 1'b0;
    @(negedge CLK); DMA_REQ = 1'b1; DMA_DO = d; DMA_LAST = lst;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (DMA_ACK) begin got = 1; break; end
    end
    DMA_REQ = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_ack_timeout: got no DMA_ACK expected one");
      return;
    end
    rd = DMA_DI;
    stable = 1'b1;
    for (int i = 0; i < 50 && DMA_ACK; i++) begin
      @(negedge CLK);
      if (DMA_ACK && DMA_DI !== rd) stable = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!BUSY) return;
      @(negedge CLK);
    end
    n_cmp++; n_bad++;
    $display("FAIL busy_timeout: got BUSY=1 expected 0");
  endtask

  task automatic xfer(input logic dir, input logic hold, input logic [2:0] add, input int n);
    int a0, e0;
    a0 = ack_cnt; e0 = end_cnt;
    dmaw(dir, hold, add);
    for (int i = 0; i < n; i++) beat(wdat[i], (i == n - 1), rdat[i], rstab[i]);
    wait_idle();
    chk("ack_count", 64'(ack_cnt - a0), 64'(n));
    chk("end_count", 64'(end_cnt - e0), 64'd1);
  endtask

  task automatic probe(input logic dir, input string name, input logic [AW+1:0] exp);
    int base;
    base = log_addr.size();
    wdat[0] = 32'h0BAD_F00D;
    if (!dir) rd_q.push_back(32'h5A5A_5A5A);
    xfer(dir, 1'b1, 3'd0, 1);
    if (base >= log_addr.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no memory cycle expected one", name);
    end else begin
      chk(name, log_addr[base], exp);
    end
  endtask

  initial begin
    int base;
    vecs[0] = '{25'h10,      3'd0, 1'b0, 32'h1000_0000, 27'h40,      27'h40};
    vecs[1] = '{25'h10,      3'd1, 1'b0, 32'h1000_0001, 27'h40,      27'h44};
    vecs[2] = '{25'h10,      3'd2, 1'b0, 32'h1000_0002, 27'h40,      27'h48};
    vecs[3] = '{25'h10,      3'd3, 1'b0, 32'h1000_0003, 27'h40,      27'h50};
    vecs[4] = '{25'h10,      3'd4, 1'b0, 32'h1000_0004, 27'h40,      27'h60};
    vecs[5] = '{25'h10,      3'd5, 1'b0, 32'h1000_0005, 27'h40,      27'h80};
    vecs[6] = '{25'h10,      3'd6, 1'b0, 32'h1000_0006, 27'h40,      27'hC0};
    vecs[7] = '{25'h10,      3'd7, 1'b0, 32'h1000_0007, 27'h40,      27'h140};
    vecs[8] = '{25'h10,      3'd7, 1'b1, 32'h1000_0008, 27'h40,      27'h40};
    vecs[9] = '{25'h1FFFFFF, 3'd1, 1'b0, 32'h1000_0009, 27'h7FFFFFC, 27'h0};

    RST_N = 1'b0; RES_N = 1'b1; DSO = '0; RA0W = 1'b0; WA0W = 1'b0; DMAW = 1'b0;
    DMA_REQ = 1'b0; DMA_DO = '0; DMA_LAST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {DMA_DI, DMA_ACK, DMA_END, 5'(MEM_A), MEM_DO, MEM_WE, MEM_REQ, BUSY}, '0);
    chk("reset_mem_a", MEM_A, '0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_after_reset", {BUSY, MEM_REQ, DMA_ACK, DMA_END}, '0);

    // table: single-beat writes covering the ADD lookup, HOLD and wrap
    for (int v = 0; v < 10; v++) begin
      set_wa0(32'(vecs[v].wa0));
      base = log_addr.size();
      wdat[0] = vecs[v].data;
      xfer(1'b1, vecs[v].hold, vecs[v].add, 1);
      chk_log($sformatf("vec%0d_write", v), base, vecs[v].exp_addr, 1'b1, vecs[v].data);
      probe(1'b1, $sformatf("vec%0d_wa0_after", v), vecs[v].exp_probe);
    end

    // 3-beat write, ADD=2, HOLD=0
    set_wa0(32'h0000_1000);
    base = log_addr.size();
    wdat[0] = 32'hAAAA_0001; wdat[1] = 32'hBBBB_0002; wdat[2] = 32'hCCCC_0003;
    xfer(1'b1, 1'b0, 3'd2, 3);
    chk_log("wr3_beat0", base,     27'h4000, 1'b1, 32'hAAAA_0001);
    chk_log("wr3_beat1", base + 1, 27'h4008, 1'b1, 32'hBBBB_0002);
    chk_log("wr3_beat2", base + 2, 27'h4010, 1'b1, 32'hCCCC_0003);
    probe(1'b1, "wr3_wa0_after", 27'h4018);

    // 2-beat read, HOLD=1
    set_ra0(32'h20);
    base = log_addr.size();
    rd_q.push_back(32'h1111_1111); rd_q.push_back(32'h2222_2222);
    xfer(1'b0, 1'b1, 3'd0, 2);
    chk("rd2_data0", rdat[0], 32'h1111_1111);
    chk("rd2_data1", rdat[1], 32'h2222_2222);
    chk("rd2_stable", {rstab[0], rstab[1]}, 2'b11);
    chk_log("rd2_beat0", base,     27'h80, 1'b0, 32'h1111_1111);
    chk_log("rd2_beat1", base + 1, 27'h84, 1'b0, 32'h2222_2222);
    probe(1'b0, "rd2_ra0_held", 27'h80);

    // 4-beat write with ADD=0: same address every beat, WA0 unchanged
    set_wa0(32'h300);
    base = log_addr.size();
    for (int i = 0; i < 4; i++) wdat[i] = 32'hC0DE_0000 + 32'(i);
    xfer(1'b1, 1'b0, 3'd0, 4);
    for (int i = 0; i < 4; i++)
      chk_log($sformatf("add0_beat%0d", i), base + i, 27'hC00, 1'b1, 32'hC0DE_0000 + 32'(i));
    probe(1'b1, "add0_wa0_after", 27'hC00);

    // read wrap at the top of the address space
    set_ra0(32'h01FF_FFFF);
    base = log_addr.size();
    rd_q.push_back(32'h3333_3333); rd_q.push_back(32'h4444_4444);
    xfer(1'b0, 1'b0, 3'd0, 2);
    chk_log("wrap_beat0", base,     27'h7FFFFFC, 1'b0, 32'h3333_3333);
    chk_log("wrap_beat1", base + 1, 27'h0,       1'b0, 32'h4444_4444);
    chk("wrap_data1", rdat[1], 32'h4444_4444);
    probe(1'b0, "wrap_ra0_after", 27'h4);

    // soft reset while a write is waiting for MEM_ACK
    mem_auto = 1'b0;
    set_wa0(32'h40);
    dmaw(1'b1, 1'b0, 3'd1);
    beat(32'hFEED_0001, 1'b0, rdat[0], rstab[0]);
    for (int i = 0; i < 20 && !MEM_REQ; i++) @(negedge CLK);
    chk("abort_req_pending", {MEM_REQ, MEM_WE, BUSY}, 3'b111);
    RES_N = 1'b0;
    @(negedge CLK);
    chk("abort_outputs", {MEM_REQ, MEM_WE, BUSY, DMA_ACK, DMA_END}, '0);
    chk("abort_mem_a", MEM_A, '0);
    RES_N = 1'b1;
    @(negedge CLK); MEM_ACK = 1'b1;
    @(negedge CLK); MEM_ACK = 1'b0;
    repeat (8) @(negedge CLK);
    chk("late_ack_ignored", {MEM_REQ, BUSY, DMA_ACK, DMA_END}, '0);
    mem_auto = 1'b1;

    // DMAW and RA0W while BUSY have no effect
    set_wa0(32'h100);
    base = log_addr.size();
    begin
      int a0, e0;
      a0 = ack_cnt; e0 = end_cnt;
      dmaw(1'b1, 1'b0, 3'd1);
      beat(32'h0101_0101, 1'b0, rdat[0], rstab[0]);
      dmaw(1'b0, 1'b1, 3'd7);
      set_ra0(32'h555);
      beat(32'h0202_0202, 1'b1, rdat[1], rstab[1]);
      wait_idle();
      chk("busy_ack_count", 64'(ack_cnt - a0), 64'd2);
      chk("busy_end_count", 64'(end_cnt - e0), 64'd1);
    end
    chk_log("busy_beat0", base,     27'h400, 1'b1, 32'h0101_0101);
    chk_log("busy_beat1", base + 1, 27'h404, 1'b1, 32'h0202_0202);
    probe(1'b1, "busy_wa0_after", 27'h408);
    probe(1'b0, "busy_ra0_kept", 27'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scu_dsp_dma_resp.md
Name: scu_dsp_dma_resp

Overview:
- SCU-side responder for the DSP D0-bus DMA engine. It holds the DSP RA0/WA0 address registers and latches the DMA instruction word when the DSP issues DMAW.
- It services the DSP's per-beat DMA_REQ by running word transfers on the SCU memory bus, then returns DMA_ACK/DMA_DI and signals completion with DMA_END.
- It sits between the DSP core and the SCU bus arbiter.

Parameters:
- AW, 25, word-address width of RA0/WA0; byte address = {addr,2'b00}.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- RES_N  in  1  synchronous soft reset, active-low
- CE_R  in  1  rising-phase clock enable; DSP samples ACK on this enable
- CE_F  in  1  falling-phase clock enable, unused internally
- DSO  in  32  DSP data/instruction word
- RA0W  in  1  write RA0 from DSO (one CLK pulse)
- WA0W  in  1  write WA0 from DSO
- DMAW  in  1  DMA start; DSO carries the instruction
- DMA_REQ  in  1  DSP requests one beat
- DMA_DO  in  32  DSP outgoing data (write direction)
- DMA_LAST  in  1  current beat is the final beat
- DMA_DI  out  32  data to DSP (read direction)
- DMA_ACK  out  1  beat accepted/delivered
- DMA_END  out  1  transfer complete strobe
- MEM_A  out  AW+2  byte address
- MEM_DO  out  32  write data
- MEM_WE  out  1  1 = write cycle
- MEM_REQ  out  1  bus request, held until MEM_ACK
- MEM_DI  in  32  read data, valid with MEM_ACK
- MEM_ACK  in  1  one-CLK completion pulse
- BUSY  out  1  transfer in progress

Behaviour:
Reset values:
- On RST_N or RES_N low, all outputs are 0 and state goes to IDLE.
- RA0, WA0, CUR, DIR, HOLD and ADD all clear.
- A reset during a transfer drops MEM_REQ immediately; the arbiter tolerates the abort.

Address registers:
- RA0W → RA0 <= DSO[AW-1:0]. WA0W → WA0 <= DSO[AW-1:0].
- Both take effect on the CLK edge where the strobe is high.
- RA0W/WA0W are ignored while BUSY=1.

DMAW (accepted only in IDLE):
- Latches DIR=DSO[12] (1 = DSP→memory).
- Latches HOLD=DSO[14].
- Latches ADD=DSO[17:15].
- Sets CUR to WA0 if DIR=1, else RA0.
- Next state is WAIT_REQ and BUSY goes to 1.
- A DMAW while BUSY is ignored.

Address step (word units):
- Read direction always steps 1 word.
- Write direction steps by the ADD lookup {0,1,2,4,8,16,32,64}.
- CUR wraps modulo 2^AW.

FSM. All DSP-facing transitions occur only on CE_R; the memory side advances on any CLK.
- WAIT_REQ, on CE_R with DMA_REQ:
  - If DIR=1: capture DMA_DO into MEM_DO, capture LAST=DMA_LAST, set DMA_ACK=1, go WR_ACK.
  - Otherwise: capture LAST, go RD_MEM.
- WR_ACK: at the next CE_R, clear DMA_ACK and go WR_MEM.
  - DMA_ACK is therefore high for exactly one CE_R period.
- WR_MEM:
  - MEM_REQ=1, MEM_WE=1, MEM_A={CUR,00}.
  - On MEM_ACK: MEM_REQ=0, CUR += step, then DONE if LAST else WAIT_REQ.
- RD_MEM:
  - MEM_REQ=1, MEM_WE=0.
  - On MEM_ACK: DMA_DI <= MEM_DI, CUR += 1, go RD_ACK.
- RD_ACK:
  - At the first CE_R, set DMA_ACK=1.
  - At the following CE_R, clear DMA_ACK, then DONE if LAST else WAIT_REQ.
  - DMA_DI stays stable until the next MEM_ACK.
- DONE, on CE_R:
  - If !HOLD, write CUR back to WA0 (DIR=1) or RA0 (DIR=0).
  - Set DMA_END=1, BUSY stays 1, go END2.
- END2: at the next CE_R, DMA_END=0, BUSY=0, go IDLE.
  - The DSP sees a CE_F between the two edges and detects the falling edge.

Other rules:
- MEM_ACK arriving outside WR_MEM/RD_MEM is ignored.
- DMA_REQ held high is not re-sampled until the state returns to WAIT_REQ.
- Beats are therefore strictly serialized: ACK is never issued twice for one REQ level.
- A single-beat transfer (DMA_LAST=1 on the first beat) goes straight to DONE after the first memory cycle.

Decomposition:
- Package scu_dsp_dma_pkg holds:
  - typedef DspDmaState_t (IDLE, WAIT_REQ, WR_ACK, WR_MEM, RD_MEM, RD_ACK, DONE, END2);
  - constants DMAI_DIR_BIT=12, DMAI_HOLD_BIT=14, DMAI_ADD_LSB=15;
  - function AddStep(ADD) returning the word step.
- No sub-module; a single FSM plus address datapath.

Test Plan:
- Read DSO=0x00001000 via WA0W, then DMAW DIR=1 ADD=2 HOLD=0, 3 beats of data A,B,C (LAST on beat 3) → MEM writes to bytes 0x4000, 0x4008, 0x4010 with A/B/C; one DMA_ACK per beat; a single DMA_END pulse; WA0 ends at 0x1006.
- RA0W=0x20, DMAW DIR=0 HOLD=1, 2 beats, memory returns 0x11111111 then 0x22222222 → DMA_DI holds each value while DMA_ACK=1; reads at 0x80 and 0x84; RA0 stays 0x20.
- Write direction with ADD=0, 4 beats → all writes hit the same address; WA0 is unchanged.
- RA0=2^25-1, 2-beat read → second address is 0 (wrap).
- RES_N low during WR_MEM with MEM_ACK pending → MEM_REQ=0 on the next CLK; BUSY, DMA_ACK and DMA_END all 0; a late MEM_ACK is ignored.
- DMAW and RA0W pulsed during BUSY → no change to the instruction fields or RA0; the transfer completes normally.
